// File: rtl/sa_frame_sequencer.sv
// ============================================================================
// Module   : sa_frame_sequencer
// Brief    : Frame sequencer for the systolic array: weight load, vector
//            stream and in-flight result tracking for the m00 stream.
//            Optional statistics counters enabled by SA_SEQ_STATS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sa_frame_sequencer #(
    parameter int LANES    = 4,
    parameter int W_BEATS  = 3,
    parameter int V_BEATS  = 12,
    parameter int PIPE_LAT = 8,
    parameter int CNT_W    = 8,
    localparam int WR_W    = (W_BEATS > 1) ? $clog2(W_BEATS) : 1
) (
    input  logic            s00_axis_aclk,
    input  logic            s00_axis_aresetn,
    input  logic            s_tvalid,
    input  logic            s_tlast,
    output logic            s_tready,
    output logic            w_we,
    output logic [WR_W-1:0] w_row,
    output logic            x_valid,
    output logic            array_ce,
    input  logic            m_tready,
    output logic            m_tvalid,
    output logic            m_tlast,
    output logic            busy,
    output logic            frame_done,
    output logic            err
`ifdef SA_SEQ_STATS_EN
    ,
    output logic [31:0]     frame_cnt,
    output logic [31:0]     stall_cnt,
    output logic [15:0]     err_cnt
`endif
);

    if (LANES < 1 || PIPE_LAT < 1 || (1 << CNT_W) <= ((W_BEATS > V_BEATS) ? W_BEATS : V_BEATS))
    begin : g_param_check
        $error("sa_frame_sequencer: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_STREAM = 3'd2,
        S_FLUSH  = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(W_BEATS - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_BEATS - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q;
    logic [PIPE_LAT-1:0] vld_q, lst_q;
    logic                acc;
    logic                err_set;
    logic                x_last;

    assign m_tvalid = vld_q[PIPE_LAT-1];
    assign m_tlast  = lst_q[PIPE_LAT-1];
    assign array_ce = !(m_tvalid && !m_tready);
    assign acc      = s_tvalid && s_tready;
    assign busy     = (state_q != S_IDLE);
    assign err      = err_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_set    = 1'b0;
        s_tready   = array_ce;
        w_we       = 1'b0;
        w_row      = '0;
        x_valid    = 1'b0;
        x_last     = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (acc) begin
                    w_we = 1'b1;
                    if (s_tlast) begin
                        err_set = 1'b1;
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end else if (W_BEATS == 1) begin
                        cnt_d   = '0;
                        state_d = S_STREAM;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = S_LOAD_W;
                    end
                end
            end
            S_LOAD_W: begin
                if (acc) begin
                    w_we  = 1'b1;
                    w_row = cnt_q[WR_W-1:0];
                    cnt_d = cnt_q + 1'b1;
                    if (s_tlast) begin
                        err_set = 1'b1;
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end else if (cnt_q == W_LAST) begin
                        cnt_d   = '0;
                        state_d = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (acc) begin
                    x_valid = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == V_LAST) begin
                        x_last  = 1'b1;
                        cnt_d   = '0;
                        err_set = !s_tlast;
                        state_d = s_tlast ? S_DRAIN : S_FLUSH;
                    end else if (s_tlast) begin
                        // Truncated frame: this beat still goes to the array as the last one.
                        x_last  = 1'b1;
                        err_set = 1'b1;
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_FLUSH: begin
                s_tready = 1'b1;
                if (acc && s_tlast) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                s_tready = 1'b0;
                if (vld_q == '0) begin
                    frame_done = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            vld_q   <= '0;
            lst_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_q | err_set;
            if (array_ce) begin
                vld_q[0] <= x_valid;
                lst_q[0] <= x_last;
                for (int i = 1; i < PIPE_LAT; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    lst_q[i] <= lst_q[i-1];
                end
            end
        end
    end

`ifdef SA_SEQ_STATS_EN
    logic [31:0] frame_cnt_q, stall_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            frame_cnt_q <= '0;
            stall_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (frame_done) frame_cnt_q <= frame_cnt_q + 1'b1;
            if (!array_ce)  stall_cnt_q <= stall_cnt_q + 1'b1;
            if (err_set && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sa_frame_sequencer.sv
// ============================================================================
// Module   : tb_sa_frame_sequencer
// Brief    : Scoreboard bench for sa_frame_sequencer (nominal, back-pressure,
//            early/missing tlast, mid-frame reset, back-to-back frames).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sa_frame_sequencer;

    localparam int W_BEATS  = 3;
    localparam int V_BEATS  = 12;
    localparam int PIPE_LAT = 8;

    logic       clk;
    logic       rst_n;
    logic       s_tvalid, s_tlast, s_tready;
    logic       w_we, x_valid, array_ce;
    logic [1:0] w_row;
    logic       m_tready, m_tvalid, m_tlast;
    logic       busy, frame_done, err;
`ifdef SA_SEQ_STATS_EN
    logic [31:0] frame_cnt, stall_cnt;
    logic [15:0] err_cnt;
`endif

    sa_frame_sequencer #(
        .LANES    (4),
        .W_BEATS  (W_BEATS),
        .V_BEATS  (V_BEATS),
        .PIPE_LAT (PIPE_LAT),
        .CNT_W    (8)
    ) dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .s_tvalid         (s_tvalid),
        .s_tlast          (s_tlast),
        .s_tready         (s_tready),
        .w_we             (w_we),
        .w_row            (w_row),
        .x_valid          (x_valid),
        .array_ce         (array_ce),
        .m_tready         (m_tready),
        .m_tvalid         (m_tvalid),
        .m_tlast          (m_tlast),
        .busy             (busy),
        .frame_done       (frame_done),
        .err              (err)
`ifdef SA_SEQ_STATS_EN
        ,
        .frame_cnt        (frame_cnt),
        .stall_cnt        (stall_cnt),
        .err_cnt          (err_cnt)
`endif
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   exp_q[$];
    int   cyc = 0;
    int   n_out = 0;
    int   n_fd = 0;
    int   last_hs_cyc = -10;
    int   fd_cyc = -1;
    int   first_mv_cyc = -1;
    int   first_iss_cyc = -1;
    int   frame_acc_cyc = -1;
    int   first_wait = 0;
    bit   bp_en = 0;
    int   bpi = 0;
    logic [3:0] bp_pat = 4'b1001;
    logic held = 1'b0;
    logic held_last = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                m_tready = bp_pat[bpi % 4];
                bpi++;
            end else begin
                m_tready = 1'b1;
            end
        end
    end

    // Output-side scoreboard: pops one expected last-flag per accepted result.
    always @(negedge clk) begin
        bit e;
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                n_checks++;
                if (m_tvalid !== 1'b1 || m_tlast !== held_last) begin
                    n_fail++;
                    $display("FAIL hold_stable: m_tvalid=%b m_tlast=%b, required 1/%b", m_tvalid, m_tlast, held_last);
                end
            end
            n_checks++;
            if (array_ce !== !(m_tvalid && !m_tready)) begin
                n_fail++;
                $display("FAIL array_ce: got %b, required %b (m_tvalid=%b m_tready=%b)", array_ce, !(m_tvalid && !m_tready), m_tvalid, m_tready);
            end
            held      = m_tvalid && !m_tready;
            held_last = m_tlast;
            if (m_tvalid === 1'b1 && first_mv_cyc < 0) first_mv_cyc = cyc;
            if (m_tvalid === 1'b1 && m_tready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_result: m_tvalid=1 m_tlast=%b, required no result", m_tlast);
                end else begin
                    e = exp_q.pop_front();
                    if (m_tlast !== e) begin
                        n_fail++;
                        $display("FAIL result_tlast: got %b, required %b", m_tlast, e);
                    end
                end
                n_out++;
                last_hs_cyc = cyc;
            end
            if (frame_done === 1'b1) begin
                n_fd++;
                fd_cyc = cyc;
                n_checks++;
                if (cyc != last_hs_cyc + 1 || exp_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL frame_done_timing: at cycle %0d pending %0d, required cycle %0d pending 0", cyc, exp_q.size(), last_hs_cyc + 1);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one frame; beats beyond W_BEATS are vector beats, tlast on beat tlast_at (0 = none).
    task automatic send_frame(input int nbeats, input int tlast_at);
        for (int b = 1; b <= nbeats; b++) begin
            int         wait_c;
            int         v;
            bit         lst, ewe, ex;
            logic [1:0] erow;
            lst      = (b == tlast_at);
            s_tvalid = 1'b1;
            s_tlast  = lst;
            wait_c   = 0;
            do begin
                @(negedge clk);
                wait_c++;
            end while (s_tready !== 1'b1 && wait_c < 200);
            if (s_tready !== 1'b1) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: s_tready=%b after %0d cycles, required 1", s_tready, wait_c);
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
                return;
            end
            if (b == 1) begin
                frame_acc_cyc = cyc;
                first_wait    = wait_c;
            end
            v    = b - W_BEATS;
            ewe  = (b <= W_BEATS);
            erow = 2'(b - 1);
            ex   = (v >= 1) && (v <= V_BEATS);
            if (ex) begin
                exp_q.push_back((v == V_BEATS) || lst);
                if (first_iss_cyc < 0) first_iss_cyc = cyc;
            end
            n_checks++;
            if (w_we !== ewe || x_valid !== ex || (ewe && w_row !== erow)) begin
                n_fail++;
                $display("FAIL beat_ctrl beat %0d: w_we=%b w_row=%0d x_valid=%b, required %b/%0d/%b", b, w_we, w_row, x_valid, ewe, erow, ex);
            end
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_fd(input int target);
        int c = 0;
        while (n_fd < target && c < 400) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (n_fd < target) begin
            n_fail++;
            $display("FAIL frame_done_timeout: got %0d frames, required %0d", n_fd, target);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if ({s_tready, array_ce, m_tvalid, m_tlast, w_we, w_row, x_valid, busy, frame_done, err} !== 11'b110_0000_0000) begin
            n_fail++;
            $display("FAIL reset_state: got %b, required 11000000000",
                     {s_tready, array_ce, m_tvalid, m_tlast, w_we, w_row, x_valid, busy, frame_done, err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_nominal(input bit exp_err);
        int n0  = n_out;
        int fd0 = n_fd;
        first_iss_cyc = -1;
        first_mv_cyc  = -1;
        send_frame(W_BEATS + V_BEATS, W_BEATS + V_BEATS);
        wait_fd(fd0 + 1);
        n_checks++;
        if (n_out - n0 != V_BEATS || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL nominal_count: got %0d outputs (%0d pending), required %0d", n_out - n0, exp_q.size(), V_BEATS);
        end
        n_checks++;
        if (first_mv_cyc - first_iss_cyc != PIPE_LAT) begin
            n_fail++;
            $display("FAIL nominal_latency: got %0d cycles, required %0d", first_mv_cyc - first_iss_cyc, PIPE_LAT);
        end
        n_checks++;
        if (err !== exp_err || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL nominal_status: err=%b busy=%b, required %b/0", err, busy, exp_err);
        end
    endtask

    task automatic test_backpressure;
        int n0  = n_out;
        int fd0 = n_fd;
`ifdef SA_SEQ_STATS_EN
        logic [31:0] st0 = stall_cnt;
`endif
        bp_en = 1'b1;
        bpi   = 0;
        send_frame(W_BEATS + V_BEATS, W_BEATS + V_BEATS);
        wait_fd(fd0 + 1);
        bp_en = 1'b0;
        n_checks++;
        if (n_out - n0 != V_BEATS || exp_q.size() != 0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_count: got %0d outputs err=%b, required %0d err=0", n_out - n0, err, V_BEATS);
        end
`ifdef SA_SEQ_STATS_EN
        n_checks++;
        if (stall_cnt == st0) begin
            n_fail++;
            $display("FAIL bp_stall_cnt: got %0d, required more than %0d", stall_cnt, st0);
        end
`endif
    endtask

    task automatic test_early_tlast;
        int n0  = n_out;
        int fd0 = n_fd;
        send_frame(W_BEATS + 5, W_BEATS + 5);
        wait_fd(fd0 + 1);
        n_checks++;
        if (n_out - n0 != 5 || exp_q.size() != 0 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL early_tlast: got %0d outputs err=%b, required 5 err=1", n_out - n0, err);
        end
`ifdef SA_SEQ_STATS_EN
        n_checks++;
        if (err_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL early_err_cnt: got %0d, required 1", err_cnt);
        end
`endif
        test_nominal(1'b1);
    endtask

    task automatic test_reset_midframe;
        int n0;
        send_frame(W_BEATS + 6, 0);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({s_tready, array_ce, m_tvalid, m_tlast, w_we, w_row, x_valid, busy, frame_done, err} !== 11'b110_0000_0000) begin
            n_fail++;
            $display("FAIL async_reset: got %b, required 11000000000",
                     {s_tready, array_ce, m_tvalid, m_tlast, w_we, w_row, x_valid, busy, frame_done, err});
        end
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
        n0 = n_out;
        repeat (20) @(negedge clk);
        n_checks++;
        if (n_out != n0 || m_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drop: got %0d outputs m_tvalid=%b, required 0/0", n_out - n0, m_tvalid);
        end
        @(posedge clk);
        #1;
        test_nominal(1'b0);
    endtask

    task automatic test_missing_tlast;
        int n0  = n_out;
        int fd0 = n_fd;
        send_frame(W_BEATS + 14, W_BEATS + 14);
        wait_fd(fd0 + 1);
        n_checks++;
        if (n_out - n0 != V_BEATS || exp_q.size() != 0 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL missing_tlast: got %0d outputs err=%b, required %0d err=1", n_out - n0, err, V_BEATS);
        end
    endtask

    task automatic test_back_to_back;
        int n0  = n_out;
        int fd0 = n_fd;
`ifdef SA_SEQ_STATS_EN
        logic [31:0] fc0 = frame_cnt;
`endif
        send_frame(W_BEATS + V_BEATS, W_BEATS + V_BEATS);
        send_frame(W_BEATS + V_BEATS, W_BEATS + V_BEATS);
        n_checks++;
        if (n_fd != fd0 + 1 || frame_acc_cyc != fd_cyc + 1 || first_wait < 2) begin
            n_fail++;
            $display("FAIL b2b_start: frames=%0d accept=%0d wait=%0d, required %0d/%0d/>=2",
                     n_fd - fd0, frame_acc_cyc, first_wait, 1, fd_cyc + 1);
        end
        wait_fd(fd0 + 2);
        n_checks++;
        if (n_out - n0 != 2 * V_BEATS || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d outputs, required %0d", n_out - n0, 2 * V_BEATS);
        end
`ifdef SA_SEQ_STATS_EN
        n_checks++;
        if (frame_cnt - fc0 != 32'd2) begin
            n_fail++;
            $display("FAIL b2b_frame_cnt: got %0d, required 2", frame_cnt - fc0);
        end
`endif
    endtask

    initial begin
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        test_reset();
        test_nominal(1'b0);
        test_backpressure();
        test_early_tlast();
        test_reset_midframe();
        test_missing_tlast();
        test_back_to_back();
        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
